// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if -- pixel-timing bundle between the VGA timing generator and
// its consumers (pixel pipeline / DAC driver).
//   pix_en      : pixel-rate enable into the generator
//   hsync/vsync : active-low sync pulses
//   video_on    : high inside the visible region
//   pixel_x/y   : current raster position (10 bits each)
//   frame_start : one-clk pulse after the raster wraps to (0,0)
//   frame_cnt   : 8-bit frame counter, present only with VGA_TIMING_FRAME_CNT_EN
// Modports: master = generator side, slave = consumer side.
interface vga_timing_gen_if;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  modport master (
    input  pix_en,
    output hsync, vsync, video_on, pixel_x, pixel_y, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, video_on, pixel_x, pixel_y, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA raster timing generator (default 640x480 @ 800x525).
// Ports:
//   clk  : system clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   vga  : vga_timing_gen_if.master (pix_en in; hsync, vsync, video_on,
//          pixel_x, pixel_y, frame_start out)
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add vga.frame_cnt, an
// 8-bit counter (reset 0) incremented modulo 256 on every frame_start pulse.
// Counters advance only on cycles with pix_en=1; hsync/vsync/video_on are
// decoded from registered phase FSMs that change on the same edge as the
// counters, so they carry no latency relative to pixel_x/pixel_y.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last count of each phase; the FSM leaves a phase on the edge that
  // advances past its last count.
  localparam logic [9:0] H_ACT_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_LAST   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SYNC_LAST = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_LAST   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SYNC_LAST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCP, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCP, V_BACK} v_state_t;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  h_state_t   h_state_q, h_state_d;
  v_state_t   v_state_q, v_state_d;
  logic       frame_start_q, frame_start_d;

  logic h_end;
  logic v_end;
  logic line_adv;
  logic frame_wrap;

  assign h_end      = (h_cnt_q == H_LAST);
  assign v_end      = (v_cnt_q == V_LAST);
  assign line_adv   = vga.pix_en & h_end;
  assign frame_wrap = line_adv & v_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_state_q     <= H_ACT;
      v_state_q     <= V_ACT;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    h_state_d     = h_state_q;
    v_state_d     = v_state_q;
    // Only a wrap edge raises the pulse, so a reset restart never does.
    frame_start_d = frame_wrap;

    if (vga.pix_en) begin
      h_cnt_d = h_end ? '0 : h_cnt_q + 10'd1;
      case (h_state_q)
        H_ACT:   if (h_cnt_q == H_ACT_LAST)  h_state_d = H_FRONT;
        H_FRONT: if (h_cnt_q == H_FP_LAST)   h_state_d = H_SYNCP;
        H_SYNCP: if (h_cnt_q == H_SYNC_LAST) h_state_d = H_BACK;
        H_BACK:  if (h_end)                  h_state_d = H_ACT;
      endcase
    end

    if (line_adv) begin
      v_cnt_d = v_end ? '0 : v_cnt_q + 10'd1;
      case (v_state_q)
        V_ACT:   if (v_cnt_q == V_ACT_LAST)  v_state_d = V_FRONT;
        V_FRONT: if (v_cnt_q == V_FP_LAST)   v_state_d = V_SYNCP;
        V_SYNCP: if (v_cnt_q == V_SYNC_LAST) v_state_d = V_BACK;
        V_BACK:  if (v_end)                  v_state_d = V_ACT;
      endcase
    end
  end

  assign vga.hsync       = (h_state_q != H_SYNCP);
  assign vga.vsync       = (v_state_q != V_SYNCP);
  assign vga.video_on    = (h_state_q == H_ACT) && (v_state_q == V_ACT);
  assign vga.pixel_x     = h_cnt_q;
  assign vga.pixel_y     = v_cnt_q;
  assign vga.frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Steps on the wrap edge, i.e. together with the rise of frame_start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
    end else if (frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- bench for vga_timing_gen. Two instances share clk, rst
// and pix_en: one with the default 800x525 timing and one with a tiny 15x11
// raster so whole frames fit in a short run. The reference model counts pixel
// advances since reset and derives position and sync/blank flags from that
// count with plain arithmetic.
module tb_vga_timing_gen;

  localparam int HT0 = 800, VT0 = 525, F0 = HT0 * VT0;
  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVA = 4, SVF = 2, SVS = 2, SVB = 3;
  localparam int HT1 = SHA + SHF + SHS + SHB;  // 15
  localparam int VT1 = SVA + SVF + SVS + SVB;  // 11
  localparam int F1  = HT1 * VT1;              // 165

  logic clk = 1'b0;
  logic rst;
  logic pix_en;

  int checks = 0;
  int errors = 0;

  vga_timing_gen_if if_d ();
  vga_timing_gen_if if_s ();
  assign if_d.pix_en = pix_en;
  assign if_s.pix_en = pix_en;

  vga_timing_gen dut_d (.clk(clk), .rst(rst), .vga(if_d));

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) dut_s (.clk(clk), .rst(rst), .vga(if_s));

  initial forever #5 clk = ~clk;

  // Reference model: pixel-advance count within the frame, and the pulse
  // that follows the edge completing a frame.
  int   n0 = 0, n1 = 0;
  logic fs0 = 1'b0, fs1 = 1'b0;
  int   fc0 = 0, fc1 = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n0 <= 0; n1 <= 0; fs0 <= 1'b0; fs1 <= 1'b0; fc0 <= 0; fc1 <= 0;
    end else begin
      if (pix_en) begin
        n0 <= (n0 + 1) % F0;
        n1 <= (n1 + 1) % F1;
      end
      fs0 <= pix_en && ((n0 + 1) % F0 == 0);
      fs1 <= pix_en && ((n1 + 1) % F1 == 0);
      if (pix_en && ((n0 + 1) % F0 == 0)) fc0 <= (fc0 + 1) % 256;
      if (pix_en && ((n1 + 1) % F1 == 0)) fc1 <= (fc1 + 1) % 256;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag, input int n, input logic fs,
                           input int ha, input int hf, input int hs_w, input int ht,
                           input int va, input int vf, input int vs_w,
                           input logic hs, input logic vs, input logic vo,
                           input logic fsd, input logic [9:0] px, input logic [9:0] py);
    int x, y;
    x = n % ht;
    y = n / ht;
    chk({tag, ".pixel_x"}, 32'(px), x);
    chk({tag, ".pixel_y"}, 32'(py), y);
    chk({tag, ".hsync"}, 32'(hs), (x >= ha + hf && x < ha + hf + hs_w) ? 0 : 1);
    chk({tag, ".vsync"}, 32'(vs), (y >= va + vf && y < va + vf + vs_w) ? 0 : 1);
    chk({tag, ".video_on"}, 32'(vo), (x < ha && y < va) ? 1 : 0);
    chk({tag, ".frame_start"}, 32'(fsd), 32'(fs));
  endtask

  always @(negedge clk) begin
    cmp_model("d", n0, fs0, 640, 16, 96, HT0, 480, 10, 2,
              if_d.hsync, if_d.vsync, if_d.video_on, if_d.frame_start,
              if_d.pixel_x, if_d.pixel_y);
    cmp_model("s", n1, fs1, SHA, SHF, SHS, HT1, SVA, SVF, SVS,
              if_s.hsync, if_s.vsync, if_s.video_on, if_s.frame_start,
              if_s.pixel_x, if_s.pixel_y);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("d.frame_cnt", 32'(if_d.frame_cnt), fc0);
    chk("s.frame_cnt", 32'(if_s.frame_cnt), fc1);
`endif
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".d.hsync"},       32'(if_d.hsync), 1);
    chk({tag, ".d.vsync"},       32'(if_d.vsync), 1);
    chk({tag, ".d.video_on"},    32'(if_d.video_on), 1);
    chk({tag, ".d.pixel_x"},     32'(if_d.pixel_x), 0);
    chk({tag, ".d.pixel_y"},     32'(if_d.pixel_y), 0);
    chk({tag, ".d.frame_start"}, 32'(if_d.frame_start), 0);
    chk({tag, ".s.hsync"},       32'(if_s.hsync), 1);
    chk({tag, ".s.vsync"},       32'(if_s.vsync), 1);
    chk({tag, ".s.video_on"},    32'(if_s.video_on), 1);
    chk({tag, ".s.pixel_x"},     32'(if_s.pixel_x), 0);
    chk({tag, ".s.pixel_y"},     32'(if_s.pixel_y), 0);
    chk({tag, ".s.frame_start"}, 32'(if_s.frame_start), 0);
  endtask

  localparam int NA = 1900;
  logic hs0 [1:NA];
  logic vo0 [1:NA];
  logic vsS [1:NA];
  logic voS [1:NA];
  logic fsS [1:NA];

  initial begin
    int f, run, nxt, cnt;
    logic [22:0] pv_d, pv_s, cur_d, cur_s;
    logic last_en, prev_hs;
    int fs_k[$];
    int hf_k[$];

    rst = 1'b1;
    pix_en = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_reset_vals("por");

    // Phase A: continuous pix_en from reset release at a falling edge, so the
    // sample taken after edge k sees raster position k.
    @(negedge clk);
    pix_en = 1'b1;
    rst = 1'b1;
    for (int k = 1; k <= NA; k++) begin
      @(negedge clk);
      hs0[k] = if_d.hsync;
      vo0[k] = if_d.video_on;
      vsS[k] = if_s.vsync;
      voS[k] = if_s.video_on;
      fsS[k] = if_s.frame_start;
    end

    // Default raster: hsync falls at x=656, low 96 clks, period 800.
    f = 0;
    for (int k = NA; k >= 1; k--) if (!hs0[k]) f = k;
    chk("a.hsync_first_low", f, 656);
    run = 0;
    for (int k = f; k <= NA && f > 0; k++) begin
      if (hs0[k]) break;
      run++;
    end
    chk("a.hsync_low_len", run, 96);
    nxt = 0;
    for (int k = NA; k > f + run && f > 0; k--) if (!hs0[k] && hs0[k-1]) nxt = k;
    chk("a.hsync_next_fall", nxt, 1456);
    cnt = 0;
    for (int k = 1; k <= 800; k++) if (vo0[k]) cnt++;
    chk("a.video_on_per_line", cnt, 640);

    // Small raster: vsync low from y=6,x=0 (k=90) for 2 lines; 165-clk frame.
    f = 0;
    for (int k = NA; k >= 1; k--) if (!vsS[k]) f = k;
    chk("a.s.vsync_first_low", f, 90);
    run = 0;
    for (int k = f; k <= NA && f > 0; k++) begin
      if (vsS[k]) break;
      run++;
    end
    chk("a.s.vsync_low_len", run, 30);
    cnt = 0;
    for (int k = 1; k <= F1; k++) if (voS[k]) cnt++;
    chk("a.s.video_on_per_frame", cnt, 32);
    cnt = 0;
    f = 0;
    for (int k = NA; k >= 1; k--) if (fsS[k]) begin cnt++; f = k; end
    chk("a.s.frame_start_count", cnt, 11);
    chk("a.s.frame_start_first", f, 165);
    chk("a.s.frame_start_second", 32'(fsS[330]), 1);

    // Mid-frame position, then asynchronous reset between edges.
    chk("a.d.x_before_reset", 32'(if_d.pixel_x), 300);
    chk("a.d.y_before_reset", 32'(if_d.pixel_y), 2);
    chk("a.s.x_before_reset", 32'(if_s.pixel_x), 10);
    chk("a.s.y_before_reset", 32'(if_s.pixel_y), 5);
    chk("a.s.hsync_before_reset", 32'(if_s.hsync), 0);
    #2 rst = 1'b0;
    #1 chk_reset_vals("mid");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Phase B: restart from (0,0) with no pulse until a real wrap.
    cnt = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 5) chk("b.d.x_after_restart", 32'(if_d.pixel_x), 5);
      if (k < F1 && if_s.frame_start) cnt++;
      if (k == F1) chk("b.s.first_wrap_pulse", 32'(if_s.frame_start), 1);
    end
    chk("b.s.no_pulse_on_restart", cnt, 0);

    // Phase C: pix_en one cycle in four; everything stretches by four and
    // stalled cycles leave outputs untouched.
    last_en = 1'b1;
    prev_hs = if_d.hsync;
    pv_d = {if_d.hsync, if_d.vsync, if_d.video_on, if_d.pixel_x, if_d.pixel_y};
    pv_s = {if_s.hsync, if_s.vsync, if_s.video_on, if_s.pixel_x, if_s.pixel_y};
    pix_en = 1'b0;
    last_en = 1'b0;
    for (int k = 1; k <= 7000; k++) begin
      @(negedge clk);
      cur_d = {if_d.hsync, if_d.vsync, if_d.video_on, if_d.pixel_x, if_d.pixel_y};
      cur_s = {if_s.hsync, if_s.vsync, if_s.video_on, if_s.pixel_x, if_s.pixel_y};
      if (!last_en) begin
        chk("c.d.stable", 32'(cur_d), 32'(pv_d));
        chk("c.s.stable", 32'(cur_s), 32'(pv_s));
        chk("c.s.stall_frame_start", 32'(if_s.frame_start), 0);
      end
      if (if_s.frame_start) fs_k.push_back(k);
      if (prev_hs && !if_d.hsync) hf_k.push_back(k);
      prev_hs = if_d.hsync;
      pv_d = cur_d;
      pv_s = cur_s;
      pix_en = (k % 4 == 0);
      last_en = pix_en;
    end
    chk("c.s.frame_pulses_seen", 32'(fs_k.size() >= 2), 1);
    if (fs_k.size() >= 2) chk("c.s.frame_period_x4", fs_k[1] - fs_k[0], 4 * F1);
    chk("c.d.hsync_falls_seen", 32'(hf_k.size() >= 2), 1);
    if (hf_k.size() >= 2) chk("c.d.hsync_period_x4", hf_k[1] - hf_k[0], 4 * HT0);

`ifdef VGA_TIMING_FRAME_CNT_EN
    // 257 frames on the small raster: the 8-bit counter wraps and reads 1.
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    pix_en = 1'b1;
    rst = 1'b1;
    for (int k = 1; k <= 257 * F1 + 2; k++) @(negedge clk);
    chk("d.s.frame_cnt_after_257", 32'(if_s.frame_cnt), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
